qpp_deinterleaver: RTL and testbench
====================================

# qpp_deinterleaver

Receive-side counterpart of the coder interleaver. Accepts a block of K bits arriving serially in QPP-interleaved order (the `cpii` ordering), with K = 1056 or 6144. Writes each bit to its original position using an incrementally generated QPP address, then drains the restored block as bytes in natural order. Used as the reference inverse in loopback tests and in the decoder-side datapath.

## Interface

Parameters:
- `K_MAX`, 6144: storage depth in bits.
- `ADDR_W`, 14: address and accumulator width. It must hold values up to 2·K_MAX−2.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  block-start strobe; sampled only in IDLE.
- `k_size_6144`  in  1  block size, sampled with `start`: 0 → K=1056, 1 → K=6144.
- `bit_in`  in  1  interleaved serial bit. Exactly one bit per cycle for K cycles after `start`; there is no gaps/valid qualifier.
- `databyte_out`  out  8  restored byte. Bit 8n+b of the block appears in byte n, bit position b (LSB = lowest index).
- `byte_valid`  out  1  `databyte_out` is valid this cycle.
- `block_done`  out  1  one-cycle pulse, coincident with the last `byte_valid`.
- `busy`  out  1  high in FILL and DRAIN.
- `k_size_out`  out  1  latched block size for the current block.

## Operation

- States: IDLE, FILL, DRAIN.
  - IDLE → FILL on `start`=1. At the same edge: latch K, set j=0, pi=0, g=(f1+f2) mod K.
  - FILL → DRAIN at the edge capturing bit K−1.
  - DRAIN → IDLE at the edge emitting byte K/8−1.
- QPP constants:
  - K=1056: f1=17, f2=66, so g0=83 and step=2·f2 mod K=132.
  - K=6144: f1=263, f2=480, so g0=743 and step=960.
- FILL, each cycle:
  - mem[pi] ← `bit_in`.
  - pi ← pi+g, minus K if the sum is ≥K.
  - g ← g+step, minus K if the sum is ≥K.
  - j ← j+1.
- Arithmetic: sums are formed at ADDR_W bits, never wider. One conditional subtract is sufficient because both operands are less than K. The result is pi(j) = (f1·j + f2·j²) mod K exactly.
- Storage: a K_MAX-bit register array. It is not cleared; a full block rewrites every address 0..K−1 because the map is a permutation. For K=1056 only addresses 0..1055 are touched.
- DRAIN: byte counter n runs 0..K/8−1 (131 or 767). Each cycle `databyte_out` ← mem[8n+7 : 8n] and `byte_valid` ← 1.
- `start` in FILL or DRAIN is ignored and has no effect on the block in progress. `k_size_6144` changes after `start` are ignored.
- Reset, any state: state ← IDLE, all counters ← 0, all outputs ← 0. A partially filled or draining block is discarded. Memory contents are don't-care.

## Timing

- `start` is sampled at edge T; bit j is sampled at edge T+1+j, for j = 0..K−1.
- Byte n is registered at edge T+K+1+n, so `byte_valid` is high for K/8 consecutive cycles. Latency from `start` to the first byte is K+1 edges.
- `block_done` is registered at the same edge as byte K/8−1; the state enters IDLE at that edge. A new `start` can be accepted on the very next edge (back-to-back, no dead cycle).
- `busy` rises at edge T and falls together with the `block_done` edge.
- `k_size_out` updates at edge T and holds until the next accepted `start`.
- Reset values: `databyte_out`=0x00, `byte_valid`=0, `block_done`=0, `busy`=0, `k_size_out`=0.

## Test plan

- K=1056, `bit_in`=1 only at j=1 (zero elsewhere) → byte 10 = 0x08 (pi(1)=83), all other 131 bytes = 0x00. First `byte_valid` occurs 1057 edges after `start`.
- K=1056, `bit_in`=1 only at j=2 → byte 37 = 0x04 (pi(2)=298), all other bytes 0x00, exactly 132 valid bytes, `block_done` on the last one.
- K=6144, `bit_in`=1 only at j=1 → byte 92 = 0x80 (pi(1)=743), 768 valid bytes. Follow with a full loopback: random 6144-bit block → interleaved by the coder interleaver → deinterleaved bytes equal the original block.
- `start` pulsed mid-FILL and mid-DRAIN → ignored; output is identical to the no-pulse run and `k_size_out` is unchanged.
- `rst`=0 for one cycle at j=500 of a K=1056 FILL → all outputs 0, IDLE. A fresh `start` then produces a correct block with no leftover bytes.
- Back-to-back blocks: K=6144 then K=1056, second `start` on the edge after `block_done` → second block is accepted, `k_size_out` goes 1→0, and both outputs are correct.

Source files
------------

// File: rtl/qpp_deinterleaver.sv
// QPP block deinterleaver: scatters an interleaved serial block into bit storage
// at incrementally generated QPP addresses, then drains it as bytes in natural order.
module qpp_deinterleaver #(
  parameter int K_MAX  = 6144,
  parameter int ADDR_W = 14
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       start,
  input  logic       k_size_6144,
  input  logic       bit_in,
  output logic [7:0] databyte_out,
  output logic       byte_valid,
  output logic       block_done,
  output logic       busy,
  output logic       k_size_out,
  output logic [1:0] fsm_state
);

  localparam int MEM_AW  = $clog2(K_MAX);
  localparam int BYTE_AW = MEM_AW - 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0]  j, pi, g;
  logic [ADDR_W-1:0]  k_val, step, g0_sel;
  logic [ADDR_W-1:0]  pi_sum, g_sum, pi_next, g_next;
  logic [BYTE_AW-1:0] n, n_last;
  logic [K_MAX-1:0]   mem;
  logic               last_bit, last_byte;

  assign fsm_state = state;

  // pi and g are both below K, so each sum is below 2K and one subtract wraps it.
  always_comb begin
    k_val     = k_size_out  ? ADDR_W'(6144) : ADDR_W'(1056);
    step      = k_size_out  ? ADDR_W'(960)  : ADDR_W'(132);
    n_last    = k_size_out  ? BYTE_AW'(767) : BYTE_AW'(131);
    g0_sel    = k_size_6144 ? ADDR_W'(743)  : ADDR_W'(83);
    pi_sum    = pi + g;
    g_sum     = g + step;
    pi_next   = (pi_sum >= k_val) ? pi_sum - k_val : pi_sum;
    g_next    = (g_sum >= k_val) ? g_sum - k_val : g_sum;
    last_bit  = (j == k_val - ADDR_W'(1));
    last_byte = (n == n_last);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FILL;
      FILL:    if (last_bit) state_next = DRAIN;
      DRAIN:   if (last_byte) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state        <= IDLE;
      j            <= '0;
      pi           <= '0;
      g            <= '0;
      n            <= '0;
      databyte_out <= 8'h00;
      byte_valid   <= 1'b0;
      block_done   <= 1'b0;
      busy         <= 1'b0;
      k_size_out   <= 1'b0;
    end else begin
      state      <= state_next;
      busy       <= (state_next != IDLE);
      byte_valid <= 1'b0;
      block_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_size_out <= k_size_6144;
            j          <= '0;
            pi         <= '0;
            g          <= g0_sel;
            n          <= '0;
          end
        end
        FILL: begin
          j  <= j + ADDR_W'(1);
          pi <= pi_next;
          g  <= g_next;
        end
        DRAIN: begin
          databyte_out <= mem[{n, 3'b000} +: 8];
          byte_valid   <= 1'b1;
          block_done   <= last_byte;
          n            <= n + BYTE_AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Storage is never cleared: a complete block rewrites every address below K.
  always_ff @(posedge clock) begin
    if (rst && state == FILL) mem[pi[MEM_AW-1:0]] <= bit_in;
  end

endmodule

// File: tb/tb_qpp_deinterleaver.sv
// Directed bench for qpp_deinterleaver: a direct-formula QPP model builds the
// restored block, and a per-cycle compare process checks every drained byte.
module tb_qpp_deinterleaver;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       k_size_6144 = 1'b0;
  logic       bit_in = 1'b0;
  logic [7:0] databyte_out;
  logic       byte_valid, block_done, busy, k_size_out;
  logic [1:0] fsm_state;

  qpp_deinterleaver dut (
    .clock       (clock),
    .rst         (rst),
    .start       (start),
    .k_size_6144 (k_size_6144),
    .bit_in      (bit_in),
    .databyte_out(databyte_out),
    .byte_valid  (byte_valid),
    .block_done  (block_done),
    .busy        (busy),
    .k_size_out  (k_size_out),
    .fsm_state   (fsm_state)
  );

  // clock / cycle counter
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc++;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] cap[768];
  logic [7:0] cap_ref[768];
  bit         stream[6144];
  bit         orig[6144];
  bit         outbits[6144];
  int         nbytes = 0;
  int         t_start = 0;
  int         exp_lat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Direct closed-form QPP address, independent of any recurrence.
  function automatic int qpp_pi(input int k, input int j);
    longint f1, f2, jj;
    f1 = (k == 6144) ? 263 : 17;
    f2 = (k == 6144) ? 480 : 66;
    jj = j;
    return int'((f1 * jj + f2 * jj * jj) % longint'(k));
  endfunction

  // scoreboard / compare process
  always @(negedge clock) begin
    if (rst) begin
      if (byte_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h with no byte expected (t=%0t)", databyte_out, $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("byte", databyte_out, e);
          if (nbytes == 0) check("first_latency", cyc - t_start, exp_lat);
          if (nbytes < 768) cap[nbytes] = databyte_out;
          check("block_done_pos", block_done, exp_q.size() == 0);
          nbytes++;
        end
      end else if (block_done) begin
        checks++;
        errors++;
        $display("FAIL stray_block_done: got 1 expected 0 (t=%0t)", $time);
      end
    end
  end

  // driver: must be called just after a negedge; returns at negedge+1
  task automatic run_block(input int k, input bit loopback, input bit pulse_fill,
                           input bit pulse_drain);
    bit got;
    for (int i = 0; i < 768; i++) cap[i] = 8'h00;
    if (!loopback) for (int j = 0; j < k; j++) outbits[qpp_pi(k, j)] = stream[j];
    for (int n = 0; n < k / 8; n++) begin
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = loopback ? orig[8*n+i] : outbits[8*n+i];
      exp_q.push_back(b);
    end
    nbytes      = 0;
    exp_lat     = k + 1;
    start       = 1'b1;
    k_size_6144 = (k == 6144);
    t_start     = cyc + 1;
    @(negedge clock);
    start       = 1'b0;
    k_size_6144 = ~k_size_6144;
    check("busy_fill", busy, 1);
    check("k_size_out_latch", k_size_out, k == 6144);
    for (int j = 0; j < k; j++) begin
      bit_in = stream[j];
      start  = pulse_fill && (j == k / 2);
      @(negedge clock);
    end
    start  = 1'b0;
    bit_in = 1'b0;
    got    = 1'b0;
    for (int i = 0; i < k / 8 + 16; i++) begin
      start = pulse_drain && (i == k / 16);
      @(negedge clock);
      if (block_done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    #1;
    check("done_seen", got, 1);
    check("byte_count", nbytes, k / 8);
    check("queue_empty", exp_q.size(), 0);
    check("busy_end", busy, 0);
    check("k_size_hold", k_size_out, k == 6144);
    exp_q.delete();
  endtask

  task automatic clear_stream();
    for (int j = 0; j < 6144; j++) stream[j] = 1'b0;
  endtask

  task automatic random_stream(input int k);
    for (int j = 0; j < k; j++) stream[j] = 1'($urandom_range(0, 1));
  endtask

  task automatic gap();
    repeat (3) @(negedge clock);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nz;
    // reset
    repeat (3) @(negedge clock);
    check("rst_databyte", databyte_out, 8'h00);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_block_done", block_done, 0);
    check("rst_busy", busy, 0);
    check("rst_k_size_out", k_size_out, 0);
    rst = 1'b1;
    @(negedge clock);

    // K=1056, single one at j=1 -> pi=83 -> byte 10 bit 3
    clear_stream();
    stream[1] = 1'b1;
    run_block(1056, 0, 0, 0);
    check("lit_1056_j1_byte10", cap[10], 8'h08);
    nz = 0;
    for (int n = 0; n < 132; n++) if (n != 10 && cap[n] != 8'h00) nz++;
    check("lit_1056_j1_others_zero", nz, 0);
    gap();

    // K=1056, single one at j=2 -> pi=298 -> byte 37 bit 2
    clear_stream();
    stream[2] = 1'b1;
    run_block(1056, 0, 0, 0);
    check("lit_1056_j2_byte37", cap[37], 8'h04);
    gap();

    // K=6144, single one at j=1 -> pi=743 -> byte 92 bit 7
    clear_stream();
    stream[1] = 1'b1;
    run_block(6144, 0, 0, 0);
    check("lit_6144_j1_byte92", cap[92], 8'h80);
    gap();

    // loopback: interleave a random block, expect the original back
    for (int j = 0; j < 6144; j++) orig[j] = 1'($urandom_range(0, 1));
    for (int j = 0; j < 6144; j++) stream[j] = orig[qpp_pi(6144, j)];
    run_block(6144, 1, 0, 0);
    gap();

    // stray start pulses during FILL and DRAIN are ignored
    random_stream(1056);
    run_block(1056, 0, 0, 0);
    for (int i = 0; i < 768; i++) cap_ref[i] = cap[i];
    gap();
    run_block(1056, 0, 1, 1);
    nz = 0;
    for (int n = 0; n < 132; n++) if (cap[n] != cap_ref[n]) nz++;
    check("pulse_run_identical", nz, 0);
    gap();

    // reset at j=500 of a K=1056 fill
    start       = 1'b1;
    k_size_6144 = 1'b0;
    @(negedge clock);
    start = 1'b0;
    for (int j = 0; j < 500; j++) begin
      bit_in = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    rst = 1'b0;
    @(negedge clock);
    check("midrst_databyte", databyte_out, 8'h00);
    check("midrst_byte_valid", byte_valid, 0);
    check("midrst_block_done", block_done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_k_size_out", k_size_out, 0);
    check("midrst_state_idle", fsm_state, 2'd0);
    rst    = 1'b1;
    bit_in = 1'b0;
    repeat (10) @(negedge clock);
    random_stream(1056);
    run_block(1056, 0, 0, 0);
    gap();

    // back-to-back: K=6144 then K=1056 on the edge after block_done
    random_stream(6144);
    run_block(6144, 0, 0, 0);
    random_stream(1056);
    run_block(1056, 0, 0, 0);
    gap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
